// File: rtl/rx_arq_ctrl.sv
// Receive-side ARQ controller. It tracks one frame from start to CRC verdict,
// answers with an ACK or a NAK, releases or flushes the buffered payload, and
// latches a sticky FAIL once a frame has been NAKed MAX_RETRY times.
// Ports:
//   i_clk, i_rst_n                    clock; async-assert / sync-release active-low reset
//   i_frame_start                     new frame detected by the serial receiver
//   i_crc_err(_valid)                 CRC verdict strobe from the demapper
//   i_arq_en(_valid)                  ARQ-enable field strobe from the demapper
//   i_ack_ready                       ACK transmitter handshake
//   i_fifo_empty                      UART TX FIFO has drained
//   i_clr_fail                        leave the FAIL state
//   o_ack_valid/o_ack_code            ACK (01) or NAK (10) request, held until i_ack_ready
//   o_fifo_flush                      one-cycle payload discard
//   o_uart_tx_en                      lets the UART drain the FIFO
//   o_retry_cnt                       NAKs issued for the current frame
//   o_fail                            sticky retry-limit flag
//   o_busy                            high whenever the state is not IDLE
module rx_arq_ctrl #(
  parameter int unsigned MAX_RETRY   = 4,
  parameter logic [19:0] TIMEOUT_CYC = 20'd100000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_start,
  input  logic       i_crc_err,
  input  logic       i_crc_err_valid,
  input  logic       i_arq_en,
  input  logic       i_arq_en_valid,
  input  logic       i_ack_ready,
  input  logic       i_fifo_empty,
  input  logic       i_clr_fail,
  output logic       o_ack_valid,
  output logic [1:0] o_ack_code,
  output logic       o_fifo_flush,
  output logic       o_uart_tx_en,
  output logic [3:0] o_retry_cnt,
  output logic       o_fail,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_ACK, S_NAK, S_RELEASE, S_FAIL
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] timer_q, timer_d;
  logic [3:0]  retry_q, retry_d;
  logic        pend_q, pend_d;
  logic        arq_en_q, arq_en_d;
  logic        ack_vld_q, ack_vld_d;
  logic [1:0]  ack_code_q, ack_code_d;
  logic        flush_q, flush_d;
  logic        tx_en_q, tx_en_d;
  logic        fail_q, fail_d;
  logic        busy_q, busy_d;
  logic [1:0]  rst_sync_q;

  logic        arq_eff;
  logic        timeout;
  logic        verdict_err;
  logic        go_recv;
  logic [3:0]  retry_inc;

  // Reset asserts immediately but releases through two flops, so the FSM
  // cannot move before the second clock edge after deassertion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  // A coincident ARQ-enable strobe overrides the latched value for this verdict.
  assign arq_eff     = i_arq_en_valid ? i_arq_en : arq_en_q;
  assign timeout     = (timer_q == TIMEOUT_CYC - 20'd1);
  // A real verdict wins; a bare timeout counts as a CRC error.
  assign verdict_err = i_crc_err_valid ? i_crc_err : 1'b1;
  // A frame start that arrived while busy (or on the leaving edge) restarts RECV.
  assign go_recv     = pend_q | i_frame_start;
  assign retry_inc   = retry_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    retry_d  = retry_q;
    pend_d   = pend_q;
    arq_en_d = arq_en_q;
    flush_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_frame_start) begin
          state_d = S_RECV;
          timer_d = 20'd0;
        end
      end
      S_RECV: begin
        timer_d = timer_q + 20'd1;
        if (i_arq_en_valid) arq_en_d = i_arq_en;
        if (i_crc_err_valid || timeout) begin
          if (arq_eff)          state_d = verdict_err ? S_NAK : S_ACK;
          else if (verdict_err) begin
            flush_d = 1'b1;
            state_d = S_IDLE;
          end
          else                  state_d = S_RELEASE;
        end
      end
      S_ACK: begin
        if (i_frame_start) pend_d = 1'b1;
        if (i_ack_ready) begin
          retry_d = 4'd0;
          state_d = S_RELEASE;
        end
      end
      S_NAK: begin
        if (i_frame_start) pend_d = 1'b1;
        if (i_ack_ready) begin
          retry_d = retry_inc;
          if (retry_inc == 4'(MAX_RETRY)) state_d = S_FAIL;
          else if (go_recv) begin
            state_d = S_RECV;
            timer_d = 20'd0;
            pend_d  = 1'b0;
          end
          else state_d = S_IDLE;
        end
      end
      S_RELEASE: begin
        if (i_frame_start) pend_d = 1'b1;
        if (i_fifo_empty) begin
          if (go_recv) begin
            state_d = S_RECV;
            timer_d = 20'd0;
            pend_d  = 1'b0;
          end
          else state_d = S_IDLE;
        end
      end
      S_FAIL: begin
        if (i_clr_fail) begin
          state_d = S_IDLE;
          retry_d = 4'd0;
          pend_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush on the first cycle of NAK only.
    if (state_d == S_NAK && state_q != S_NAK) flush_d = 1'b1;

    // Outputs are decoded from the next state so they come straight from flops.
    ack_vld_d  = (state_d == S_ACK) || (state_d == S_NAK);
    ack_code_d = (state_d == S_ACK) ? 2'b01 : (state_d == S_NAK) ? 2'b10 : 2'b00;
    tx_en_d    = (state_d == S_RELEASE);
    fail_d     = (state_d == S_FAIL);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= 20'd0;
      retry_q    <= 4'd0;
      pend_q     <= 1'b0;
      arq_en_q   <= 1'b1;
      ack_vld_q  <= 1'b0;
      ack_code_q <= 2'b00;
      flush_q    <= 1'b0;
      tx_en_q    <= 1'b0;
      fail_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else if (rst_sync_q[1]) begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      pend_q     <= pend_d;
      arq_en_q   <= arq_en_d;
      ack_vld_q  <= ack_vld_d;
      ack_code_q <= ack_code_d;
      flush_q    <= flush_d;
      tx_en_q    <= tx_en_d;
      fail_q     <= fail_d;
      busy_q     <= busy_d;
    end
  end

  assign o_ack_valid  = ack_vld_q;
  assign o_ack_code   = ack_code_q;
  assign o_fifo_flush = flush_q;
  assign o_uart_tx_en = tx_en_q;
  assign o_retry_cnt  = retry_q;
  assign o_fail       = fail_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_rx_arq_ctrl.sv
// Bench for rx_arq_ctrl: directed scenarios followed by random stimulus, all
// cycles compared against a frame-level behavioural model.
// Latency: outputs compared 1 time unit after each rising edge.
module tb_rx_arq_ctrl;

  localparam int MAXR = 4;
  localparam int TO   = 16;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_frame_start = 1'b0, i_crc_err = 1'b0, i_crc_err_valid = 1'b0;
  logic       i_arq_en = 1'b0, i_arq_en_valid = 1'b0, i_ack_ready = 1'b0;
  logic       i_fifo_empty = 1'b0, i_clr_fail = 1'b0;
  logic       o_ack_valid, o_fifo_flush, o_uart_tx_en, o_fail, o_busy;
  logic [1:0] o_ack_code;
  logic [3:0] o_retry_cnt;

  rx_arq_ctrl #(.MAX_RETRY(MAXR), .TIMEOUT_CYC(20'd16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_start(i_frame_start),
    .i_crc_err(i_crc_err), .i_crc_err_valid(i_crc_err_valid),
    .i_arq_en(i_arq_en), .i_arq_en_valid(i_arq_en_valid),
    .i_ack_ready(i_ack_ready), .i_fifo_empty(i_fifo_empty), .i_clr_fail(i_clr_fail),
    .o_ack_valid(o_ack_valid), .o_ack_code(o_ack_code), .o_fifo_flush(o_fifo_flush),
    .o_uart_tx_en(o_uart_tx_en), .o_retry_cnt(o_retry_cnt), .o_fail(o_fail),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: which phase of the frame handshake we are in, plus bookkeeping.
  localparam int M_IDLE = 0, M_RECV = 1, M_ACK = 2, M_NAK = 3, M_REL = 4, M_FAIL = 5;
  int         m_ph, m_age, m_hold;
  logic [3:0] m_retry;
  bit         m_pend, m_arq, m_flush;

  task automatic model_reset();
    m_ph = M_IDLE; m_age = 0; m_retry = 0; m_pend = 0; m_arq = 1; m_flush = 0; m_hold = 0;
  endtask

  task automatic start_frame();
    m_ph = M_RECV; m_age = 0; m_pend = 0;
  endtask

  task automatic model_edge();
    bit eff, err, fl;
    if (!i_rst_n) return;
    if (m_hold > 0) begin m_hold--; return; end
    fl = 0;
    if (i_frame_start && (m_ph == M_ACK || m_ph == M_NAK || m_ph == M_REL)) m_pend = 1;
    case (m_ph)
      M_IDLE: if (i_frame_start) start_frame();
      M_RECV: begin
        eff = i_arq_en_valid ? i_arq_en : m_arq;
        if (i_arq_en_valid) m_arq = i_arq_en;
        if (i_crc_err_valid || m_age == TO - 1) begin
          err = i_crc_err_valid ? i_crc_err : 1'b1;
          if (eff) begin m_ph = err ? M_NAK : M_ACK; fl = err; end
          else if (err) begin fl = 1; m_ph = M_IDLE; end
          else m_ph = M_REL;
        end else m_age++;
      end
      M_ACK: if (i_ack_ready) begin m_retry = 0; m_ph = M_REL; end
      M_NAK: if (i_ack_ready) begin
        m_retry = m_retry + 1;
        if (m_retry == MAXR) m_ph = M_FAIL;
        else if (m_pend) start_frame();
        else m_ph = M_IDLE;
      end
      M_REL: if (i_fifo_empty) begin
        if (m_pend) start_frame(); else m_ph = M_IDLE;
      end
      M_FAIL: if (i_clr_fail) begin m_ph = M_IDLE; m_retry = 0; m_pend = 0; end
      default: m_ph = M_IDLE;
    endcase
    m_flush = fl;
  endtask

  function automatic logic [10:0] exp_vec();
    logic [1:0] code;
    code = (m_ph == M_ACK) ? 2'b01 : (m_ph == M_NAK) ? 2'b10 : 2'b00;
    return {(m_ph == M_ACK || m_ph == M_NAK), code, m_flush, (m_ph == M_REL),
            m_retry, (m_ph == M_FAIL), (m_ph != M_IDLE)};
  endfunction

  logic [10:0] got_vec;
  assign got_vec = {o_ack_valid, o_ack_code, o_fifo_flush, o_uart_tx_en,
                    o_retry_cnt, o_fail, o_busy};

  task automatic cyc(input bit fs, cv, ce, av, a, rdy, fe, clr);
    i_frame_start = fs; i_crc_err_valid = cv; i_crc_err = ce;
    i_arq_en_valid = av; i_arq_en = a; i_ack_ready = rdy;
    i_fifo_empty = fe; i_clr_fail = clr;
    @(posedge i_clk);
    model_edge();
    #1;
    chk("cycle", 32'(got_vec), 32'(exp_vec()));
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst", 32'(got_vec), 32'd0);
    cyc(1, 1, 1, 0, 0, 1, 1, 0);
    i_rst_n = 1'b1;
    m_hold = 2;
  endtask

  initial begin
    model_reset();
    #1;
    chk("reset", 32'(got_vec), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    i_rst_n = 1'b1;
    m_hold = 2;
    // Frame starts during the release window must be ignored.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("sync_release", 32'(o_busy), 32'd0);

    // Clean frame: ACK for one cycle, release until FIFO empty.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 1, 0, 0);
    chk("ack_code", 32'({o_ack_valid, o_ack_code}), 32'b101);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("rel_txen", 32'({o_uart_tx_en, o_ack_valid}), 32'b10);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    chk("idle_after_rel", 32'({o_busy, o_uart_tx_en}), 32'b00);

    // Four failing frames reach the retry limit.
    for (int k = 0; k < MAXR; k++) begin
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 0, 0, 1, 0, 0);
      chk("nak_flush", 32'({o_fifo_flush, o_ack_code}), 32'b110);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      chk("retry_cnt", 32'(o_retry_cnt), 32'(k + 1));
    end
    chk("fail_set", 32'(o_fail), 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("fail_ignores_start", 32'({o_fail, o_ack_valid}), 32'b10);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("clr_fail", 32'({o_fail, o_busy, o_retry_cnt}), 32'd0);

    // Timeout produces a NAK on the 16th cycle after RECV entry.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (TO - 1) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_timeout", 32'(o_ack_valid), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("timeout_nak", 32'({o_ack_valid, o_ack_code}), 32'b110);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    // Verdict coinciding with timeout wins.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (TO - 1) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    chk("verdict_wins", 32'({o_ack_valid, o_ack_code}), 32'b101);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);

    // ARQ disabled by a coincident strobe, error: flush only.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 0, 0);
    chk("noarq_flush", 32'({o_fifo_flush, o_ack_valid, o_busy}), 32'b100);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("noarq_pulse", 32'(o_fifo_flush), 32'd0);

    // Long ACK wait with a frame start pending, then direct RECV entry.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(i == 10, 0, 0, 0, 0, 0, 0, 0);
      chk("ack_hold", 32'({o_ack_valid, o_ack_code}), 32'b101);
    end
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    chk("direct_recv", 32'({o_busy, o_uart_tx_en, o_ack_valid}), 32'b100);

    // Reset during a pending ACK handshake.
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_ack", 32'(o_ack_valid), 32'd1);
    do_reset();
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else cyc($urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0, 1'($urandom),
               $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
